// File: rtl/pipe_pkg.sv
// Shared constants for the pipelined DLX-style core: stage numbering,
// forwarding-select encoding, result-ready stages and register address width.
package pipe_pkg;

  localparam int REG_ADDR_W  = 6;

  localparam int STG_EX      = 1;
  localparam int STG_MEM     = 2;
  localparam int STG_WB      = 3;

  localparam int FWD_REGFILE = 0;

  localparam int RDY_ALU     = 1;
  localparam int RDY_LOAD    = 2;
  localparam int RDY_FPU     = 1;

  // A ready stage of 0 means "available out of EX", same as an ALU result.
  function automatic int eff_ready(input int rdy);
    return (rdy == 0) ? RDY_ALU : rdy;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source priority encoder over the in-flight scoreboard: picks the
// youngest matching producer and decides between forwarding and stalling.
module hazard_src_match #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int DEPTH      = 3,
  parameter int SEL_W      = 3
) (
  input  logic [REG_ADDR_W-1:0]       src_addr,
  input  logic                        src_used,
  input  logic [DEPTH-1:0]            pipe_valid,
  input  logic [DEPTH*REG_ADDR_W-1:0] pipe_addr,
  input  logic [DEPTH*SEL_W-1:0]      pipe_ready,
  output logic [SEL_W-1:0]            sel,
  output logic                        need_stall
);
  import pipe_pkg::*;

  // Scan oldest to youngest so the smallest stage index is written last and wins.
  always_comb begin
    sel        = SEL_W'(FWD_REGFILE);
    need_stall = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_used && (src_addr != '0) && pipe_valid[k-1] &&
          (pipe_addr[(k-1)*REG_ADDR_W +: REG_ADDR_W] == src_addr)) begin
        if (eff_ready(int'(pipe_ready[(k-1)*SEL_W +: SEL_W])) > k) begin
          need_stall = 1'b1;
          sel        = SEL_W'(FWD_REGFILE);
        end else begin
          need_stall = 1'b0;
          sel        = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection / forwarding controller with a DEPTH-entry shift scoreboard.
// Optional stall-cycle counter enabled by HAZARD_STALL_COUNTER_EN.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int DEPTH      = 3,
  parameter int SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_we,
  input  logic [SEL_W-1:0]      rd_ready,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_a_sel,
  output logic [SEL_W-1:0]      fwd_b_sel,
  output logic [31:0]           stall_count
);
  import pipe_pkg::*;

  // Bit/slice k-1 holds scoreboard entry k (entry 1 = EX).
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH*REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH*SEL_W-1:0]      ready_q, ready_d;

  logic [REG_ADDR_W-1:0] src_addr [2];
  logic                  src_used [2];
  logic [SEL_W-1:0]      src_sel  [2];
  logic                  src_need [2];

  assign src_addr[0] = rs1_addr;
  assign src_used[0] = rs1_used;
  assign src_addr[1] = rs2_addr;
  assign src_used[1] = rs2_used;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      hazard_src_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH),
        .SEL_W      (SEL_W)
      ) u_match (
        .src_addr   (src_addr[gi]),
        .src_used   (src_used[gi]),
        .pipe_valid (valid_q),
        .pipe_addr  (addr_q),
        .pipe_ready (ready_q),
        .sel        (src_sel[gi]),
        .need_stall (src_need[gi])
      );
    end
  endgenerate

  assign stall     = issue_valid & (src_need[0] | src_need[1]) & ~flush;
  assign fwd_a_sel = src_sel[0];
  assign fwd_b_sel = src_sel[1];

  // A stalled or flushed decode slot enters EX as a bubble; r0 writes are never tracked.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    if (!hold) begin
      valid_d = {valid_q[DEPTH-2:0],
                 issue_valid & rd_we & ~stall & ~flush & (rd_addr != '0)};
      addr_d  = {addr_q[(DEPTH-1)*REG_ADDR_W-1:0], rd_addr};
      ready_d = {ready_q[(DEPTH-1)*SEL_W-1:0], rd_ready};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      addr_q  <= '0;
      ready_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !hold) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_q <= 32'd0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit (DEPTH=3): expected stall/select
// triples are queued as each decode cycle is driven and popped at mid-cycle.
module tb_pipeline_hazard_unit;

  logic       clk;
  logic       reset;
  logic       hold;
  logic       flush;
  logic       issue_valid;
  logic [5:0] rs1_addr;
  logic       rs1_used;
  logic [5:0] rs2_addr;
  logic       rs2_used;
  logic [5:0] rd_addr;
  logic       rd_we;
  logic [2:0] rd_ready;
  logic       stall;
  logic [2:0] fwd_a_sel;
  logic [2:0] fwd_b_sel;
  logic [31:0] stall_count;

  typedef struct {
    string      tag;
    logic       st;
    logic [2:0] a;
    logic [2:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_unit #(.REG_ADDR_W(6), .DEPTH(3), .SEL_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .flush       (flush),
    .issue_valid (issue_valid),
    .rs1_addr    (rs1_addr),
    .rs1_used    (rs1_used),
    .rs2_addr    (rs2_addr),
    .rs2_used    (rs2_used),
    .rd_addr     (rd_addr),
    .rd_we       (rd_we),
    .rd_ready    (rd_ready),
    .stall       (stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    rs1_addr = '0; rs1_used = 1'b0; rs2_addr = '0; rs2_used = 1'b0;
    rd_addr = '0; rd_we = 1'b0; rd_ready = '0;
  endtask

  // Called at posedge+1; drives one decode cycle, checks at the falling edge.
  task automatic step(input string tag, input logic iv,
                      input logic [5:0] a1, input logic u1,
                      input logic [5:0] a2, input logic u2,
                      input logic [5:0] rd, input logic we, input logic [2:0] rdy,
                      input logic hd, input logic fl,
                      input logic es, input logic [2:0] ea, input logic [2:0] eb);
    exp_t e;
    issue_valid = iv; rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2;
    rd_addr = rd; rd_we = we; rd_ready = rdy; hold = hd; flush = fl;
    exp_q.push_back('{tag, es, ea, eb});
    #4;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({e.tag, ".stall"}, 32'(stall), 32'(e.st));
      check_val({e.tag, ".fwd_a"}, 32'(fwd_a_sel), 32'(e.a));
      check_val({e.tag, ".fwd_b"}, 32'(fwd_b_sel), 32'(e.b));
      $display("step %s stall=%0b a=%0d b=%0d", e.tag, stall, fwd_a_sel, fwd_b_sel);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    //   tag          iv rs1  u1 rs2  u2 rd   we rdy hd fl  st a b
    step("rst_empty", 1, 6'd5, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 0, 0);
    check_val("rst_count", stall_count, 32'd0);
    for (int i = 0; i < 3; i++)
      step("fill_r5", 1, 6'd0, 0, 6'd0, 0, 6'd5, 1, 3'd1, 0, 0, 0, 0, 0);
    reset_pulse();
    step("rst_full",  1, 6'd5, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 0, 0);

    // ALU-ALU forwarding walks through every stage, then back to the regfile.
    step("add_r3",    1, 6'd0, 0, 6'd0, 0, 6'd3, 1, 3'd1, 0, 0, 0, 0, 0);
    step("use_r3_k1", 1, 6'd3, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 1, 0);
    step("use_r3_k2", 1, 6'd3, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 2, 0);
    step("use_r3_k3", 1, 6'd3, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 3, 0);
    step("use_r3_rf", 1, 6'd3, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 0, 0);

    // Load-use: one stall, then stage-2 forward; stalled write r9 enters afterwards.
    step("lw_r4",     1, 6'd0, 0, 6'd0, 0, 6'd4, 1, 3'd2, 0, 0, 0, 0, 0);
    step("lu_stall",  1, 6'd0, 0, 6'd4, 1, 6'd9, 1, 3'd1, 0, 0, 1, 0, 0);
    step("lu_fwd",    1, 6'd0, 0, 6'd4, 1, 6'd9, 1, 3'd1, 0, 0, 0, 0, 2);
    step("lu_after",  1, 6'd9, 1, 6'd4, 1, 6'd0, 0, 3'd0, 0, 0, 0, 1, 3);
`ifdef HAZARD_STALL_COUNTER_EN
    check_val("count_lu", stall_count, 32'd1);
`else
    check_val("count_lu", stall_count, 32'd0);
`endif

    step("w_r7_a",    1, 6'd0, 0, 6'd0, 0, 6'd7, 1, 3'd1, 0, 0, 0, 0, 0);
    step("w_r7_b",    1, 6'd7, 1, 6'd0, 0, 6'd7, 1, 3'd1, 0, 0, 0, 1, 0);
    step("young_r7",  1, 6'd7, 1, 6'd7, 1, 6'd0, 0, 3'd0, 0, 0, 0, 1, 1);
    step("w_r0",      1, 6'd0, 0, 6'd0, 0, 6'd0, 1, 3'd1, 0, 0, 0, 0, 0);
    step("use_r0",    1, 6'd0, 1, 6'd0, 1, 6'd0, 0, 3'd0, 0, 0, 0, 0, 0);
    step("w_f0",      1, 6'd0, 0, 6'd0, 0, 6'd32, 1, 3'd1, 0, 0, 0, 0, 0);
    step("use_f0",    1, 6'd32, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 1, 0);

    // Flush overrides a load-use stall; the squashed write r10 must not be tracked.
    step("lw_r4_b",   1, 6'd0, 0, 6'd0, 0, 6'd4, 1, 3'd2, 0, 0, 0, 0, 0);
    step("flush_lu",  1, 6'd0, 0, 6'd4, 1, 6'd10, 1, 3'd1, 0, 1, 0, 0, 0);
    step("post_fl",   1, 6'd10, 1, 6'd4, 1, 6'd0, 0, 3'd0, 0, 0, 0, 0, 2);

    // Hold freezes the scoreboard; the write r12 offered during hold is dropped.
    step("w_r15",     1, 6'd0, 0, 6'd0, 0, 6'd15, 1, 3'd1, 0, 0, 0, 0, 0);
    step("w_r11",     1, 6'd0, 0, 6'd0, 0, 6'd11, 1, 3'd1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("held",    1, 6'd11, 1, 6'd15, 1, 6'd12, 1, 3'd1, 1, 0, 0, 1, 2);
    step("unheld",    1, 6'd11, 1, 6'd15, 1, 6'd12, 0, 3'd0, 0, 0, 0, 1, 2);
    step("shifted",   1, 6'd11, 1, 6'd12, 1, 6'd0, 0, 3'd0, 0, 0, 0, 2, 0);

    step("w_r14_rdy0", 1, 6'd0, 0, 6'd0, 0, 6'd14, 1, 3'd0, 0, 0, 0, 0, 0);
    step("use_r14",    1, 6'd14, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 1, 0);
    step("w_r13_rdy5", 1, 6'd0, 0, 6'd0, 0, 6'd13, 1, 3'd5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("wait_r13", 1, 6'd13, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 1, 0, 0);
    step("r13_rf",     1, 6'd13, 1, 6'd0, 0, 6'd0, 0, 3'd0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STALL_COUNTER_EN
    check_val("count_rdy5", stall_count, 32'd4);
`else
    check_val("count_rdy5", stall_count, 32'd0);
`endif

    // Held stall cycles are not counted.
    reset_pulse();
    check_val("count_clr", stall_count, 32'd0);
    step("lw_r4_c",   1, 6'd0, 0, 6'd0, 0, 6'd4, 1, 3'd2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      step("held_lu", 1, 6'd0, 0, 6'd4, 1, 6'd0, 0, 3'd0, 1, 0, 1, 0, 0);
    step("lu_stall_c", 1, 6'd0, 0, 6'd4, 1, 6'd0, 0, 3'd0, 0, 0, 1, 0, 0);
    step("lu_fwd_c",   1, 6'd0, 0, 6'd4, 1, 6'd0, 0, 3'd0, 0, 0, 0, 0, 2);
`ifdef HAZARD_STALL_COUNTER_EN
    check_val("count_hold", stall_count, 32'd1);
`else
    check_val("count_hold", stall_count, 32'd0);
`endif
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
